uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
UART receiver for 8N1 frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high). It samples the asynchronous rx line using a baud counter derived from the system clock. Each completed byte is presented with a one-cycle valid strobe and a framing-error flag. It is the receive-side counterpart of the team's 9600-baud, 12 MHz UART transmitter and sits between the board RX pin and the byte consumer.

Parameters:
FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line bit rate
LIM, FREQ/BAUD (1250), clocks per bit; the counter width is clog2(LIM), which is 11 bits at the defaults
HALF, LIM/2 (625), clocks from detection of the start edge to the middle of the start bit

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  synchronous active-low reset
rx  in  1  serial line input, asynchronous, idle high
data_out  out  8  last received byte
valid  out  1  one-cycle strobe; data_out and frame_err are valid in this cycle
frame_err  out  1  the stop bit sampled low for the byte being strobed
busy  out  1  high while a frame is in progress (any state other than IDLE)
bit_count  out  4  index of the data bit being received, 0..7 (for debug)

Behaviour:
- Reset: clk is the clock; nrst is synchronous and active-low, sampled on the rising edge of clk.
  - Outputs at reset: data_out=0, valid=0, frame_err=0, busy=0, bit_count=0.
  - Internal state at reset: state=IDLE, baud counter=0, shift register=0, sync flops=1.
  - An nrst assertion during a frame aborts it immediately, with no valid pulse.
- Input sync: rx passes through a 2-flop synchronizer, giving rx_s; all decisions use rx_s. The synchronizer adds 2 clocks of latency, which is included in every timing figure below.
- States (2-bit encoding): IDLE=00, START=01, DATA=11, STOP=10.
- IDLE: the counter is held at 0.
  - A falling edge of rx_s (previous value 1, current 0) moves to START with the counter cleared.
  - A line held low out of reset is not treated as a start.
- START: the counter counts to HALF-1, then samples rx_s.
  - rx_s=0: go to DATA, clear the counter, clear bit_count.
  - rx_s=1: a glitch or false start. Return to IDLE with no valid pulse.
- DATA: the counter counts 0..LIM-1. At LIM-1 it samples rx_s into shift[7] and shifts right, so LSB-first data ends up aligned.
  - bit_count increments after each sample.
  - After the sample with bit_count=7, go to STOP.
- STOP: the counter counts to LIM-1, then samples rx_s.
  - data_out is loaded with the shift register.
  - frame_err is set to the complement of rx_s.
  - valid is high for exactly that one cycle.
  - The state returns to IDLE in the same cycle.
  - A byte with a framing error is still delivered.
- Re-arm: a new start edge is accepted from the first IDLE cycle after STOP.
  - If rx_s is still low after a framing error, the receiver waits in IDLE for rx_s=1 and then a falling edge. This prevents repeated triggering on a break condition.
- Timing from the rx falling edge to the valid strobe: 2 (sync) + 1 (edge detect) + HALF + 8*LIM + LIM cycles, with a tolerance of ±1 cycle. At the defaults this is 11,878 ±1 clocks.
- Sampling position: each data bit is sampled within ±1 clock of its nominal centre.
- Arithmetic: the counter compares against LIM-1 and HALF-1 exactly; no rounding is applied beyond integer division.
- Outputs: data_out and frame_err hold their values until the next valid pulse. busy=1 whenever state≠IDLE.

Optional Feature:
RX_MAJORITY_EN
- Defined: each bit is decided by a 2-of-3 majority vote of rx_s sampled at counter values mid-1, mid and mid+1, where mid is HALF-1 for the start bit and LIM-1 for data and stop bits. The counter target shifts by +1 so that the decision is made at mid+1. End-to-end latency therefore grows by 1 clock, and single-cycle glitches are rejected.
- Undefined: a single sample is taken per bit, exactly as specified in Behaviour.
- The port list is identical in both cases.

Test Plan:
- Send 0x53 at 9600 baud with a correct stop bit → one valid pulse, data_out=0x53, frame_err=0. The pulse arrives 11,878 ±1 clocks after the start edge (+1 clock with RX_MAJORITY_EN).
- Send 0x6E, 0x61, 0x70 back to back with no idle gap → three valid pulses exactly 12,500 ±1 clocks apart, carrying 0x6E, 0x61, 0x70 in that order, all with frame_err=0.
- Send 0xA5 with the stop bit forced low → valid pulses with data_out=0xA5 and frame_err=1. With the line then held low for 3 bit times before returning high, there is no further valid pulse until a new frame is sent.
- Drive a 200-clock low pulse on idle rx → no valid pulse, busy returns to 0 within 627 clocks, and a following 0x00 frame is received correctly.
- Assert nrst for 1 cycle mid-way through bit 4 of a 0xFF frame → all outputs are 0 on the next cycle. No valid pulse occurs for the aborted frame, and the next full frame (0x3C) is received correctly.
- With RX_MAJORITY_EN defined, inject a 1-clock high glitch at the centre of every data bit of 0x00 → data_out=0x00 and frame_err=0. Without the macro, the same stimulus yields 0xFF.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around its centre.
module uart_rx_8n1 #(
    parameter int FREQ = 12000000,
    parameter int BAUD = 9600
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] bit_count
);
    localparam int LIM  = FREQ / BAUD;
    localparam int HALF = LIM / 2;
    localparam int CW   = $clog2(LIM);
`ifdef RX_MAJORITY_EN
    localparam int ADJ = 1;
`else
    localparam int ADJ = 0;
`endif
    localparam logic [CW-1:0] START_END = CW'(HALF - 1 + ADJ);
    localparam logic [CW-1:0] BIT_END   = CW'(LIM - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b11, STOP = 2'b10} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    bit_q, bit_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic          rx_s;
    logic          bit_val;

    assign rx_s   = sync_q[1];
    assign sync_d = {sync_q[0], rx};
    assign prev_d = rx_s;
    assign fill_d = {fill_q[0], 1'b1};
    // The sync flops reset high, so only arm once rx_s really reflects the line being high.
    assign armed_d = armed_q | (fill_q[1] & rx_s);

`ifdef RX_MAJORITY_EN
    logic prev2_q, prev2_d;
    assign prev2_d = prev_q;
    assign bit_val = (prev2_q & prev_q) | (prev2_q & rx_s) | (prev_q & rx_s);
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev2_q <= 1'b1;
        end else begin
            prev2_q <= prev2_d;
        end
    end
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q;
        data_d  = data_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == START_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {bit_val, shift_q[7:1]};
                    if (bit_q == 4'd7) state_d = STOP;
                    else bit_d = bit_q + 4'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    ferr_d  = !bit_val;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
    assign bit_count = bit_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: scoreboard bench for uart_rx_8n1 at a reduced clock/baud ratio.
// Expected bytes, flags and strobe times come from the frame-level rules, not the RTL.
module tb_uart_rx_8n1;
    localparam int FREQ = 1200000;
    localparam int BAUD = 9600;
    localparam int LIM  = FREQ / BAUD;
    localparam int HALF = LIM / 2;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam longint LAT = 3 + HALF + 9 * LIM + MAJ;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b0;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;
    logic [3:0] bit_count;

    int     tests = 0;
    int     fails = 0;
    int     pulses = 0;
    int     pushed = 0;
    longint cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        longint     t;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx_8n1 #(.FREQ(FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .nrst(nrst), .rx(rx), .data_out(data_out), .valid(valid),
        .frame_err(frame_err), .busy(busy), .bit_count(bit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // A 1-clock high glitch at every data-bit centre reads as all ones unless voting removes it.
    function automatic logic [7:0] model_byte(input logic [7:0] b, input bit glitch);
        return (glitch && MAJ == 0) ? 8'hFF : b;
    endfunction

    always @(negedge clk) begin
        if (nrst && valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: data_out=0x%0h at cycle %0d, no frame pending", data_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", data_out, mon_e.d);
                check("frame_err", frame_err, mon_e.fe);
                tests++;
                if (cyc < mon_e.t - 1 || cyc > mon_e.t + 1) begin
                    fails++;
                    $display("FAIL valid_time: strobe at cycle %0d, expected %0d +/-1", cyc, mon_e.t);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit stop, input bit glitch);
        exp_q.push_back('{model_byte(b, glitch), !stop, cyc + LAT});
        pushed++;
        rx = 1'b0;
        repeat (LIM) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch) begin
                repeat (HALF) @(negedge clk);
                rx = 1'b1;
                @(negedge clk);
                rx = b[i];
                repeat (LIM - HALF - 1) @(negedge clk);
            end else begin
                repeat (LIM) @(negedge clk);
            end
        end
        rx = stop;
        repeat (LIM) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_bit_count"}, bit_count, 0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs, rg;
        longint     c0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("held_low_busy", busy, 0);
        idle(LIM);
        send(8'h53, 1, 0);
        idle(LIM);
        send(8'h6E, 1, 0);
        send(8'h61, 1, 0);
        send(8'h70, 1, 0);
        idle(LIM);
        send(8'hA5, 0, 0);
        rx = 1'b0;
        repeat (3 * LIM) @(negedge clk);
        idle(2 * LIM);
        check("pulses_after_break", pulses, pushed);
        rx = 1'b0;
        repeat (LIM) @(negedge clk);
        rx = 1'b1;
        repeat (4 * LIM + LIM / 2) @(negedge clk);
        check("abort_bit_count", bit_count, 4);
        nrst = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        nrst = 1'b1;
        idle(5 * LIM);
        check("pulses_after_abort", pulses, pushed);
        send(8'h3C, 1, 0);
        idle(LIM);
        c0 = cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("false_start_busy", busy, 1);
        repeat (HALF / 3 - 4) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < HALF + 8 && busy === 1'b1; i++) @(negedge clk);
        check("false_start_idle", busy, 0);
        check("false_start_in_time", (cyc - c0) <= HALF + 4, 1);
        check("pulses_after_false_start", pulses, pushed);
        idle(LIM);
        send(8'h00, 1, 0);
        idle(LIM);
        send(8'h00, 1, 1);
        idle(LIM);
        repeat (12) begin
            rb = 8'($urandom);
            rs = ($urandom_range(3) != 0);
            rg = ($urandom_range(3) == 0);
            send(rb, rs, rg);
            idle(rs ? $urandom_range(HALF) : LIM);
        end
        idle(1);
        for (int i = 0; i < 4 * LIM && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        check("total_pulses", pulses, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
